// File: rtl/miriscv_prefetch_fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage (master) and memory (slave).
interface miriscv_prefetch_fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/miriscv_prefetch_fetch_stage.sv
// Prefetching fetch stage: sequential requests with credit-limited issue, response queue, redirect/flush.
// Optional same-cycle response bypass to decode is enabled by defining MIRISCV_FETCH_BYPASS_EN.
module miriscv_prefetch_fetch_stage #(
    parameter int XLEN            = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] boot_addr_i,
    input  logic            cu_stall_f_i,
    input  logic            cu_kill_f_i,
    input  logic            cu_force_f_i,
    input  logic [XLEN-1:0] cu_force_pc_i,
    output logic            f_stall_req_o,
    miriscv_prefetch_fetch_stage_if.master instr,
    output logic [XLEN-1:0] f_instr_o,
    output logic [XLEN-1:0] f_current_pc_o,
    output logic [XLEN-1:0] f_next_pc_o,
    output logic            f_valid_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  queue_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] outstanding_nxt;

    logic queue_nempty;
    logic rsp_valid;
    logic rsp_keep;
    logic bypass_hit;
    logic issue;
    logic pop;
    logic pop_queue;
    logic push;

    assign queue_nempty = (count != '0);
    assign rsp_valid    = instr.rvalid && (outstanding != '0);
    assign rsp_keep     = rsp_valid && (discard == '0);

`ifdef MIRISCV_FETCH_BYPASS_EN
    assign bypass_hit = rsp_keep && !queue_nempty && !cu_force_f_i;
`else
    assign bypass_hit = 1'b0;
`endif

    // Credit rule: every granted request already owns a queue slot, so rvalid never needs back-pressure.
    assign issue = !rst_i && !cu_force_f_i
                   && (outstanding < CNT_W'(MAX_OUTSTANDING))
                   && (({1'b0, outstanding} + {1'b0, count}) < (CNT_W + 1)'(FIFO_DEPTH));

    assign instr.req  = issue;
    assign instr.addr = fetch_pc;

    assign f_valid_o      = (queue_nempty || bypass_hit) && !cu_kill_f_i;
    assign f_stall_req_o  = !(queue_nempty || bypass_hit);
    assign f_instr_o      = queue_nempty ? queue_mem[rd_ptr] : (bypass_hit ? instr.rdata : '0);
    assign f_current_pc_o = head_pc;
    assign f_next_pc_o    = head_pc + XLEN'(4);

    assign pop       = f_valid_o && !cu_stall_f_i && !cu_force_f_i;
    assign pop_queue = pop && queue_nempty;
    // A pop from an empty queue can only be a bypassed response, which then skips the queue.
    assign push      = rsp_keep && !cu_force_f_i && !(pop && !queue_nempty);

    assign outstanding_nxt = outstanding + CNT_W'(issue && instr.gnt) - CNT_W'(rsp_valid);

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            queue_mem[wr_ptr] <= instr.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= boot_addr_i;
            head_pc     <= boot_addr_i;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (cu_force_f_i) begin
                fetch_pc <= cu_force_pc_i;
                head_pc  <= cu_force_pc_i;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                // Whatever is still in flight after this cycle belongs to the squashed stream.
                discard  <= outstanding_nxt;
            end else begin
                if (issue && instr.gnt) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (pop) begin
                    head_pc <= head_pc + XLEN'(4);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_queue) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop_queue);
                if (rsp_valid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (rst_i) !(instr.rvalid && (outstanding == '0)))
        else $error("instr_rvalid with no outstanding request");
`endif

endmodule
